// File: rtl/token_sched_pkg.sv
// Shared types and constants for the token double scheduler.
// Optional drop counter is enabled by defining TOKEN_SCHED_DROP_CNT_EN.
package token_sched_pkg;

  typedef enum logic [0:0] {StIdle, StServe} state_t;

  localparam int unsigned MAX_N_REQ  = 8;
  localparam int unsigned DROP_CNT_W = 16;
  // Tokens one requester can lose on a single edge (MULT <= 4).
  localparam int unsigned DROP_W     = 3;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/token_backlog_cnt.sv
// Per-requester backlog: saturating add-MULT / drain-one counter with sticky overflow.
// TOKEN_SCHED_DROP_CNT_EN adds a per-edge dropped-token count output.
module token_backlog_cnt
  import token_sched_pkg::*;
#(
  parameter int unsigned MULT     = 2,
  parameter int unsigned MAX_PEND = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              add,
  input  logic              drain,
  output logic              nonzero,
  output logic              last,
  output logic              overflow
`ifdef TOKEN_SCHED_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0] dropped
`endif
);

  localparam int unsigned SumW = CNT_W + 3;
  localparam logic [SumW-1:0] MaxSum  = SumW'(MAX_PEND);
  localparam logic [SumW-1:0] MultSum = SumW'(MULT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [SumW-1:0]  sum;

  always_comb begin
    sum = SumW'(cnt_q) + (add ? MultSum : '0) - (drain ? SumW'(1) : '0);
    ovf_d = ovf_q;
    cnt_d = sum[CNT_W-1:0];
`ifdef TOKEN_SCHED_DROP_CNT_EN
    dropped = '0;
`endif
    if (sum > MaxSum) begin
      cnt_d = CNT_W'(MAX_PEND);
      ovf_d = 1'b1;
`ifdef TOKEN_SCHED_DROP_CNT_EN
      dropped = DROP_W'(sum - MaxSum);
`else
      // Excess tokens are simply discarded.
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign nonzero  = (cnt_q != '0);
  assign last     = (cnt_q == CNT_W'(1));
  assign overflow = ovf_q;

endmodule

// File: rtl/token_double_scheduler.sv
// Round-robin, burst-limited drain of N_REQ token backlogs onto one serial output.
// Define TOKEN_SCHED_DROP_CNT_EN to add the saturating drop_cnt output.
module token_double_scheduler
  import token_sched_pkg::*;
#(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned MULT     = 2,
  parameter int unsigned MAX_PEND = 255,
  parameter int unsigned BURST    = 4,
  localparam int unsigned ID_W    = id_width(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      a,
  output logic                  b,
  output logic [ID_W-1:0]       b_id,
  output logic                  busy,
  output logic [N_REQ-1:0]      overflow
`ifdef TOKEN_SCHED_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);
  localparam int unsigned BST_W = $clog2(BURST + 1);

  logic [N_REQ-1:0] nonzero, last, drain;
  logic [ID_W-1:0]  gnt_q, gnt_d, sel, idx;
  logic [BST_W-1:0] burst_q, burst_d;
  logic             keep, emit, found;
  state_t           state_q, state_d;

`ifdef TOKEN_SCHED_DROP_CNT_EN
  logic [DROP_W-1:0] dropped [N_REQ];
`endif

  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    token_backlog_cnt #(
      .MULT    (MULT),
      .MAX_PEND(MAX_PEND),
      .CNT_W   (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .add     (a[i]),
      .drain   (drain[i]),
      .nonzero (nonzero[i]),
      .last    (last[i]),
      .overflow(overflow[i])
`ifdef TOKEN_SCHED_DROP_CNT_EN
      ,
      .dropped (dropped[i])
`endif
    );
  end

  assign emit = |nonzero;
  // burst_q == 0 means no live grant (after reset or idle), so the old owner is not kept.
  assign keep = nonzero[gnt_q] && (burst_q != '0) && (burst_q < BST_W'(BURST));

  always_comb begin
    sel   = gnt_q;
    found = 1'b0;
    idx   = '0;
    if (!keep) begin
      for (int unsigned k = 1; k <= N_REQ; k++) begin
        idx = ID_W'((32'(gnt_q) + k) % N_REQ);
        if (!found && nonzero[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end
  end

  assign drain = emit ? (N_REQ'(1) << sel) : '0;
  assign b     = emit;
  assign b_id  = emit ? sel : '0;
  assign busy  = (state_q == StServe);

  always_comb begin
    gnt_d   = gnt_q;
    burst_d = '0;
    if (emit) begin
      gnt_d   = sel;
      burst_d = keep ? burst_q + BST_W'(1) : BST_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|a) state_d = StServe;
      StServe: if (!(|a) && ((nonzero & ~drain) == '0) && (!emit || last[sel])) begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      burst_q <= '0;
      state_q <= StIdle;
    end else begin
      gnt_q   <= gnt_d;
      burst_q <= burst_d;
      state_q <= state_d;
    end
  end

`ifdef TOKEN_SCHED_DROP_CNT_EN
  localparam int unsigned DropSumW = DROP_CNT_W + 1;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DropSumW-1:0]   drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int unsigned i = 0; i < N_REQ; i++) begin
      drop_sum = drop_sum + DropSumW'(dropped[i]);
    end
    drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  // No drop accounting in this build.
`endif

endmodule

// File: tb/tb_token_double_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-level model.
module tb_token_double_scheduler;

  localparam int N     = 2;
  localparam int MULT  = 2;
  localparam int MAXP  = 255;
  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] a = '0;
  logic       b;
  logic [0:0] b_id;
  logic       busy;
  logic [1:0] overflow;
`ifdef TOKEN_SCHED_DROP_CNT_EN
  logic [15:0] drop_cnt;
  logic [15:0] obs_drop;
`endif

  always #5 clk = ~clk;

  token_double_scheduler #(
    .N_REQ   (N),
    .MULT    (MULT),
    .MAX_PEND(MAXP),
    .BURST   (BURST)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .b_id    (b_id),
    .busy    (busy),
    .overflow(overflow)
`ifdef TOKEN_SCHED_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: pending tokens per requester, current owner and its run length.
  int     bl[N];
  bit     ovf[N];
  int     gnt;
  int     burst;
  longint drops;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      bl[i]  = 0;
      ovf[i] = 1'b0;
    end
    gnt   = 0;
    burst = 0;
    drops = 0;
  endfunction

  function automatic bit model_keep();
    return bl[gnt] > 0 && burst > 0 && burst < BURST;
  endfunction

  function automatic int model_pick();
    if (model_keep()) return gnt;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (gnt + k) % N;
      if (bl[j] > 0) return j;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic [1:0] av);
    int s;
    bit kp;
    kp = model_keep();
    s  = model_pick();
    for (int i = 0; i < N; i++) begin
      int nxt;
      nxt = bl[i] + (av[i] ? MULT : 0) - ((s == i) ? 1 : 0);
      if (nxt > MAXP) begin
        drops  += nxt - MAXP;
        nxt    = MAXP;
        ovf[i] = 1'b1;
      end
      bl[i] = nxt;
    end
    if (s >= 0) begin
      burst = (kp && s == gnt) ? burst + 1 : 1;
      gnt   = s;
    end else begin
      burst = 0;
    end
  endfunction

  // Compare process: outputs must match the model every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        int s;
        logic [1:0] ev;
        s = model_pick();
        for (int i = 0; i < N; i++) ev[i] = ovf[i];
        chk("model_b", b, (s >= 0) ? 1 : 0);
        chk("model_b_id", b_id, (s >= 0) ? s : 0);
        chk("model_busy", busy, (s >= 0) ? 1 : 0);
        chk("model_overflow", overflow, ev);
`ifdef TOKEN_SCHED_DROP_CNT_EN
        chk("model_drop_cnt", drop_cnt, (drops > 65535) ? 65535 : drops);
`endif
      end
    end
  end

  // One cycle: observe outputs, apply a, and advance the model over the edge.
  task automatic drive(input logic [1:0] av, output logic ob, output logic oid,
                       output logic obusy, output logic [1:0] oovf);
    @(negedge clk);
    ob    = b;
    oid   = b_id;
    obusy = busy;
    oovf  = overflow;
`ifdef TOKEN_SCHED_DROP_CNT_EN
    obs_drop = drop_cnt;
`endif
    a = av;
    @(posedge clk);
    model_step(av);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    a     = '0;
    model_reset();
    #1;
    chk({tag, "_rst_b"}, b, 0);
    chk({tag, "_rst_busy"}, busy, 0);
    chk({tag, "_rst_ovf"}, overflow, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  logic       ob, oid, obusy;
  logic [1:0] oovf;
  int         pat_a[7] = '{1, 0, 0, 1, 0, 0, 0};
  int         pat_b[7] = '{0, 1, 1, 0, 1, 1, 0};
  int         cnt1;
  int         dens;
`ifdef TOKEN_SCHED_DROP_CNT_EN
  logic [15:0] d0;
`endif

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_b", b, 0);
    chk("init_busy", busy, 0);
    chk("init_ovf", overflow, 0);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single requester, sparse tokens.
    do_reset("t1");
    for (int t = 0; t < 7; t++) begin
      drive({1'b0, pat_a[t] != 0}, ob, oid, obusy, oovf);
      chk("t1_b", ob, pat_b[t]);
      chk("t1_id", oid, 0);
      chk("t1_busy", obusy, pat_b[t]);
    end

    // One simultaneous token each: four outputs, two per requester, requester 1 first.
    do_reset("t2");
    drive(2'b11, ob, oid, obusy, oovf);
    cnt1 = 0;
    for (int t = 0; t < 5; t++) begin
      drive(2'b00, ob, oid, obusy, oovf);
      chk("t2_b", ob, (t < 4) ? 1 : 0);
      if (t == 0) chk("t2_first_id", oid, 1);
      if (ob && oid) cnt1++;
    end
    chk("t2_id1_count", cnt1, 2);

    // Both saturated: grants alternate in blocks of BURST.
    do_reset("t3");
    drive(2'b11, ob, oid, obusy, oovf);
    chk("t3_b0", ob, 0);
    for (int t = 1; t <= 16; t++) begin
      drive(2'b11, ob, oid, obusy, oovf);
      chk("t3_b", ob, 1);
      chk("t3_id", oid, (((t - 1) / BURST) % 2 == 0) ? 1 : 0);
    end

    // Overflow on the 255th consecutive token, then sticky through drain.
    do_reset("t4");
    for (int t = 0; t < 254; t++) drive(2'b01, ob, oid, obusy, oovf);
    drive(2'b01, ob, oid, obusy, oovf);
    chk("t4_ovf_254", oovf, 2'b00);
    drive(2'b00, ob, oid, obusy, oovf);
    chk("t4_ovf_255", oovf, 2'b01);
    for (int t = 0; t < 260; t++) drive(2'b00, ob, oid, obusy, oovf);
    drive(2'b00, ob, oid, obusy, oovf);
    chk("t4_drained_b", ob, 0);
    chk("t4_sticky_ovf", oovf, 2'b01);

    // Reset mid-burst with backlog 10 and overflow still set.
    for (int t = 0; t < 9; t++) drive(2'b01, ob, oid, obusy, oovf);
    drive(2'b00, ob, oid, obusy, oovf);
    chk("t5_pre_b", ob, 1);
    chk("t5_pre_ovf", oovf, 2'b01);
    do_reset("t5");
    for (int t = 0; t < 5; t++) begin
      drive(2'b00, ob, oid, obusy, oovf);
      chk("t5_post_b", ob, 0);
      chk("t5_post_busy", obusy, 0);
    end

`ifdef TOKEN_SCHED_DROP_CNT_EN
    // Both backlogs pinned at MAX_PEND: 4 in, 1 out, so 3 dropped per cycle.
    do_reset("t6");
    for (int t = 0; t < 400; t++) drive(2'b11, ob, oid, obusy, oovf);
    d0 = obs_drop;
    for (int t = 0; t < 10; t++) drive(2'b11, ob, oid, obusy, oovf);
    chk("t6_drop_delta", obs_drop - d0, 30);
`endif

    // Random traffic with segment-wise density, occasional reset.
    do_reset("rnd");
    for (int seg = 0; seg < 20; seg++) begin
      dens = $urandom_range(4);
      if (seg % 7 == 6) do_reset("rnd_mid");
      for (int t = 0; t < 200; t++) begin
        logic [1:0] av;
        for (int i = 0; i < N; i++) begin
          av[i] = ($urandom_range(99) < dens * 25) || (dens == 4);
        end
        drive(av, ob, oid, obusy, oovf);
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
